// File: rtl/sodor_stim_pkg.sv
// Shared constants, enums and LFSR step for the Sodor RV32I stimulus generator.
package sodor_stim_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {CLS_R, CLS_IALU, CLS_LOAD} cls_e;
  typedef enum logic [1:0] {IDLE, GEN, DRAIN, DONE} state_e;

  // One xorshift32 step: x^=x<<13; x^=x>>17; x^=x<<5.
  function automatic logic [XLEN-1:0] xorshift32_step(input logic [XLEN-1:0] x);
    logic [XLEN-1:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

endpackage

// File: rtl/sodor_instr_stim_gen_if.sv
// Valid/ready instruction stream between the stimulus generator and its consumer.
interface sodor_instr_stim_gen_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;

  modport master (output instr_valid, output instr, input  instr_ready);
  modport slave  (input  instr_valid, input  instr, output instr_ready);
endinterface

// File: rtl/sodor_xorshift32.sv
// Seedable xorshift32 state register; exposes the value it would take on the next step.
module sodor_xorshift32
  import sodor_stim_pkg::*;
#(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            step,
  input  logic            load,
  output logic [XLEN-1:0] nxt_c
);

  // A zero seed would lock xorshift at zero forever.
  localparam logic [XLEN-1:0] SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;

  logic [XLEN-1:0] x;

  assign nxt_c = xorshift32_step(x);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  x <= SEED_EFF;
    else if (load) x <= SEED_EFF;
    else if (step) x <= nxt_c;
  end

endmodule

// File: rtl/sodor_instr_stim_gen.sv
// Random RV32I R/I-ALU/LOAD instruction stream with a fixed-length burst, NOP drain and done flag.
module sodor_instr_stim_gen
  import sodor_stim_pkg::*;
#(
  parameter logic [31:0] SEED         = 32'h0000_0001,
  parameter int unsigned BURST_LEN    = 64,
  parameter int unsigned DRAIN_NOPS   = 5,
  parameter logic [4:0]  REG_MASK     = 5'b11111,
  parameter logic [2:0]  LOAD_F3_MASK = 3'b100,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [2:0]                    class_en,
  sodor_instr_stim_gen_if.master        bus,
  output logic [CNT_W-1:0]              instr_count,
  output logic                          done
);

  localparam int unsigned RUN_W = 32;

  state_e           state, state_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             nop_q, nop_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [RUN_W-1:0] burst_q, burst_d;
  logic [RUN_W-1:0] drain_q, drain_d;
  logic             step_c;
  logic             accept_c;
  logic [XLEN-1:0]  lfsr_nxt_c;

  sodor_xorshift32 #(.SEED(SEED)) u_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (step_c),
    .load    (1'b0),
    .nxt_c   (lfsr_nxt_c)
  );

  // Field encoding; a disabled candidate class falls back to the lowest enabled one.
  function automatic logic [XLEN-1:0] encode(input logic [XLEN-1:0] x, input logic [2:0] en);
    cls_e            cand;
    cls_e            cls;
    logic            cand_on;
    logic [4:0]      rs1, rs2, rd;
    logic [2:0]      f3;
    logic [11:0]     imm;
    logic [6:0]      f7;
    logic [XLEN-1:0] word;
    case (x[1:0])
      2'b01:   cand = CLS_IALU;
      2'b10:   cand = CLS_LOAD;
      default: cand = CLS_R;
    endcase
    case (cand)
      CLS_IALU: cand_on = en[1];
      CLS_LOAD: cand_on = en[2];
      default:  cand_on = en[0];
    endcase
    if (cand_on)    cls = cand;
    else if (en[0]) cls = CLS_R;
    else if (en[1]) cls = CLS_IALU;
    else            cls = CLS_LOAD;
    rs2 = x[24:20] & REG_MASK;
    rs1 = x[19:15] & REG_MASK;
    rd  = x[11:7]  & REG_MASK;
    f3  = x[14:12];
    imm = x[31:20];
    f7  = 7'h00;
    case (cls)
      CLS_R: begin
        if ((f3 == 3'd0 || f3 == 3'd5) && x[30]) f7 = 7'h20;
        word = {f7, rs2, rs1, f3, rd, OP_R};
      end
      CLS_IALU: begin
        if (f3 == 3'd1)      imm[11:5] = 7'h00;
        else if (f3 == 3'd5) imm[11:5] = {1'b0, x[30], 5'b0};
        word = {imm, rs1, f3, rd, OP_IMM};
      end
      CLS_LOAD: word = {imm, rs1, f3 & LOAD_F3_MASK, rd, OP_LOAD};
      default:  word = NOP_INSTR;
    endcase
    if (en == 3'b000) word = NOP_INSTR;
    return word;
  endfunction

  assign accept_c = valid_q && bus.instr_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state;
    instr_d = instr_q;
    valid_d = valid_q;
    done_d  = done_q;
    nop_d   = nop_q;
    count_d = count_q;
    burst_d = burst_q;
    drain_d = drain_q;
    step_c  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          step_c  = 1'b1;
          count_d = '0;
          burst_d = '0;
          drain_d = '0;
          if (BURST_LEN != 0) begin
            state_d = GEN;
            valid_d = 1'b1;
            done_d  = 1'b0;
            instr_d = encode(lfsr_nxt_c, class_en);
            nop_d   = (class_en == 3'b000);
          end else if (DRAIN_NOPS != 0) begin
            state_d = DRAIN;
            valid_d = 1'b1;
            done_d  = 1'b0;
            instr_d = NOP_INSTR;
          end else begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
            instr_d = NOP_INSTR;
          end
        end
      end
      GEN: begin
        if (accept_c) begin
          step_c  = 1'b1;
          burst_d = burst_q + RUN_W'(1);
          if (!nop_q && count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
          if (burst_q + RUN_W'(1) == BURST_LEN) begin
            instr_d = NOP_INSTR;
            if (DRAIN_NOPS != 0) begin
              state_d = DRAIN;
            end else begin
              state_d = DONE;
              valid_d = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            instr_d = encode(lfsr_nxt_c, class_en);
            nop_d   = (class_en == 3'b000);
          end
        end
      end
      DRAIN: begin
        if (accept_c) begin
          drain_d = drain_q + RUN_W'(1);
          if (drain_q + RUN_W'(1) == DRAIN_NOPS) begin
            state_d = DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      nop_q   <= 1'b0;
      count_q <= '0;
      burst_q <= '0;
      drain_q <= '0;
    end else begin
      state   <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      nop_q   <= nop_d;
      count_q <= count_d;
      burst_q <= burst_d;
      drain_q <= drain_d;
    end
  end

  assign bus.instr_valid = valid_q;
  assign bus.instr       = instr_q;
  assign instr_count     = count_q;
  assign done            = done_q;

endmodule

// File: doc/sodor_instr_stim_gen.md
Name: sodor_instr_stim_gen

Overview:
Synthesizable, seedable random RV32I instruction stimulus generator for Sodor-5 co-simulation and formal harnesses. It replaces bench-side $urandom loops that emitted a single instruction class. It produces a valid/ready stream of R-type, I-type ALU and load instructions, with per-class enables and register-field masking. After a programmable burst it appends NOP drain cycles and reports done, so pipeline and model state can be compared at a quiescent point.

Parameters:
SEED, 32'h0000_0001, initial xorshift32 state; must be nonzero, 0 is replaced by 1
BURST_LEN, 64, instructions emitted per run before drain
DRAIN_NOPS, 5, NOPs emitted after the burst; covers the 5-stage pipeline
REG_MASK, 5'b11111, ANDed into rd/rs1/rs2 to restrict register pressure
LOAD_F3_MASK, 3'b100, ANDed into load funct3; the default gives LB/LBU only
CNT_W, 16, width of the instruction counter

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a run from IDLE or DONE
class_en  in  3  enable mask: [0]=R-type, [1]=I-ALU, [2]=LOAD
instr_valid  out  1  instr holds a valid instruction
instr_ready  in  1  consumer accepts when valid&&ready
instr  out  32  instruction word; 32'h00000013 whenever not in GEN
instr_count  out  CNT_W  non-NOP instructions accepted in the current run
done  out  1  high in DONE state

Behaviour:
- Reset (async assert, sync deassert) values: state=IDLE, lfsr=SEED (or 1 if SEED==0), instr=32'h00000013, instr_valid=0, instr_count=0, done=0.
- Reset mid-run aborts immediately. There is no pending output after reset.
- LFSR is xorshift32: x^=x<<13; x^=x>>17; x^=x<<5. It steps once on each start and on each accepted GEN transfer, and never otherwise.
- Instruction fields are decoded from the current lfsr x:
  - rs2=x[24:20]&REG_MASK, rs1=x[19:15]&REG_MASK, rd=x[11:7]&REG_MASK, f3=x[14:12], imm=x[31:20].
  - Class candidate from x[1:0]: 00/11=R, 01=I-ALU, 10=LOAD.
  - If the candidate is disabled in class_en, use the lowest enabled class.
  - If class_en==0, emit a NOP, which is counted as valid but not in instr_count.
- R-type: opcode 0110011. funct7=7'h20 iff f3 in {0,5} and x[30]; else 0.
- I-ALU: opcode 0010011. f3==1: imm[11:5]=0. f3==5: imm[11:5]={1'b0,x[30],5'b0}.
- LOAD: opcode 0000011, funct3=f3&LOAD_F3_MASK, imm=x[31:20].
- FSM:
  - IDLE: valid=0; on start go to GEN.
  - GEN: valid=1, instr=decoded word. Hold instr and lfsr stable while !ready. On accept, instr_count++ and the lfsr steps. When the accepted count reaches BURST_LEN, go to DRAIN.
  - DRAIN: valid=1, instr=NOP. Count accepted NOPs; after DRAIN_NOPS go to DONE.
  - DONE: valid=0, done=1. start clears instr_count, steps the lfsr and goes to GEN (the seed sequence continues).
- Latency: the first valid instruction appears the cycle after start is sampled.
- Boundary cases:
  - start while in GEN/DRAIN is ignored.
  - class_en changes take effect on the next decoded word only. The held word never changes while valid&&!ready.
  - BURST_LEN=0 goes straight from start to DRAIN.
  - DRAIN_NOPS=0 goes straight to DONE.
  - instr_count saturates at all-ones.

Decomposition:
- Package sodor_stim_pkg: opcode constants (OP_R, OP_IMM, OP_LOAD), NOP_INSTR, class enum {CLS_R, CLS_IALU, CLS_LOAD}, state enum {IDLE, GEN, DRAIN, DONE}.
- One sub-module: sodor_xorshift32 (state reg, step enable, load-seed input).
- Field encoding stays as combinational logic in the top.

Test Plan:
- Hold reset_n=0, toggle start, class_en=3'b111 -> instr=32'h00000013, valid=0, done=0, count=0 throughout.
- SEED=1, class_en=3'b001, ready=1, pulse start -> lfsr=32'h00042021; first instr=32'h00042033 (slt x0,x8,x0) with valid=1 the next cycle.
- Same setup, hold ready=0 for 4 cycles -> instr stays 32'h00042033, count stays 0; with ready=1 count becomes 1 and the word changes.
- class_en=3'b010 for 1000 words -> every f3=1 word has instr[31:25]=0; every f3=5 word has instr[31:25] in {0,7'h20}; every opcode is 0010011.
- class_en=3'b100, LOAD_F3_MASK=3'b100 -> every opcode is 0000011 and funct3 is in {0,4}.
- BURST_LEN=3, DRAIN_NOPS=5, ready=1 -> 3 non-NOP words then 5 NOPs, done=1 at cycle 9 after start, instr_count=3; a second start resumes and count restarts at 0.
